// File: rtl/dff.sv
`timescale 1ns/1ps
// dff -- enable-gated WIDTH-bit D register with asynchronous active-low reset.
//
// Captures d on the rising edge of clk when en is high and holds otherwise.
// q is driven straight from flops, so there is no combinational path from
// d or en to q. reset_n forces q to RESET_VALUE immediately, without
// waiting for clk. Deassertion of reset_n must already be synchronized to
// clk by the surrounding logic.
//
// Parameters:
//   WIDTH        data width, 1..64
//   RESET_VALUE  value held on q while reset_n is low
//
// Ports:
//   clk      in   1      sole clock, rising edge
//   reset_n  in   1      asynchronous reset, active low
//   d        in   WIDTH  data to capture
//   en       in   1      load enable, sampled on the rising edge of clk
//   q        out  WIDTH  registered data
//   loaded   out  1      only when DFF_LOADED_FLAG_EN is defined. High once
//                        q holds captured data rather than RESET_VALUE.
//
// Build option: define DFF_LOADED_FLAG_EN to add the loaded output and its flop.
module dff #(
   parameter int unsigned            WIDTH       = 4,
   parameter logic [WIDTH-1:0]       RESET_VALUE = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   input  logic             en,
`ifdef DFF_LOADED_FLAG_EN
   output logic             loaded,
`endif
   output logic [WIDTH-1:0] q
);

   // Plain mux in front of the flop. An X on en shows up in simulation
   // and is not filtered.
   logic [WIDTH-1:0] q_next;

   always_comb begin
      q_next = en ? d : q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) q <= RESET_VALUE;
      else          q <= q_next;
   end

`ifdef DFF_LOADED_FLAG_EN
   // Sticky flag. It sets on the first enabled edge after reset and clears
   // only on reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  loaded <= 1'b0;
      else if (en)   loaded <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_dff.sv
`timescale 1ns/1ps
// tb_dff -- directed test of dff with WIDTH=4 and RESET_VALUE=0.
// clk has a 10 ns period, with rising edges at 5, 15, 25 ns and so on.
// Inputs change on multiples of 10 ns. Outputs are sampled 3 ns after the
// rising edges (8, 18, ...), and also between edges for the asynchronous
// reset checks and the no-combinational-path checks.
module tb_dff;
   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] d;
   logic       en;
   logic [3:0] q;
`ifdef DFF_LOADED_FLAG_EN
   logic       loaded;
`endif

   int total = 0;
   int bad   = 0;

   dff #(.WIDTH(4), .RESET_VALUE(4'h0)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (d),
      .en      (en),
`ifdef DFF_LOADED_FLAG_EN
      .loaded  (loaded),
`endif
      .q       (q)
   );

   always #5 clk = ~clk;

   task automatic at(input time t);
      if (t > $time) #(t - $time);
   endtask

   task automatic chk_q(input string tag, input logic [3:0] exp);
      total++;
      assert (q === exp) else begin
         bad++;
         $error("FAIL %s: q=%h expected=%h at %0t", tag, q, exp, $time);
      end
   endtask

   task automatic chk_l(input string tag, input logic exp);
`ifdef DFF_LOADED_FLAG_EN
      total++;
      assert (loaded === exp) else begin
         bad++;
         $error("FAIL %s: loaded=%b expected=%b at %0t", tag, loaded, exp, $time);
      end
`endif
   endtask

   initial begin
      // Hold reset from 0 to 20 ns. d toggles and en goes high during it.
      reset_n = 1'b0; d = 4'h0; en = 1'b0;
      at(2);   chk_q("rst_async_init", 4'h0); chk_l("rst_loaded_init", 1'b0);
      at(10);  d = 4'h1; en = 1'b1;             // reset must beat en at edge 15
      at(18);  chk_q("rst_wins_over_en", 4'h0); chk_l("rst_loaded_en", 1'b0);
      at(20);  reset_n = 1'b1; en = 1'b0;
      at(28);  chk_q("post_rst_en0", 4'h0); chk_l("post_rst_loaded", 1'b0);

      // First enabled load
      at(40);  en = 1'b1; d = 4'h1;
      at(42);  chk_q("no_comb_path", 4'h0);
      at(48);  chk_q("load_1", 4'h1); chk_l("loaded_set", 1'b1);

      // q follows d while en is high
      at(60);  d = 4'h0;
      at(68);  chk_q("follow_0", 4'h0);
      at(78);  chk_q("follow_0_again", 4'h0);

      // Hold while en is low
      at(80);  en = 1'b0; d = 4'h1;
      at(88);  chk_q("hold_85", 4'h0);
      at(98);  chk_q("hold_95", 4'h0);
      at(100); en = 1'b1;
      at(108); chk_q("load_105", 4'h1);
      at(120); en = 1'b0; d = 4'h0;
      at(128); chk_q("hold_125", 4'h1);
      at(168); chk_q("hold_165", 4'h1); chk_l("loaded_sticky", 1'b1);

      // Re-enable, then load all four bits
      at(170); en = 1'b1; d = 4'h1;
      at(178); chk_q("reenable_175", 4'h1);
      at(180); d = 4'hA;
      at(188); chk_q("full_width_A", 4'hA);
      at(190); en = 1'b0; d = 4'h5;
      at(198); chk_q("hold_A", 4'hA);

      // Asynchronous reset between edges (no rising edge between 195 and 205)
      at(200); reset_n = 1'b0;
      at(201); chk_q("async_mid_hold", 4'h0); chk_l("async_loaded_clr", 1'b0);
      at(210); reset_n = 1'b1; en = 1'b0; d = 4'hF;
      at(228); chk_q("post_rst2_hold", 4'h0); chk_l("post_rst2_loaded", 1'b0);
      at(230); en = 1'b1;
      at(238); chk_q("load_F", 4'hF); chk_l("loaded_reset_again", 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
